// File: rtl/fetch_imem_if.sv
// Instruction-memory request/response bundle between the fetch stage (master)
// and the instruction memory (slave); one request outstanding at most.
interface fetch_imem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  imem_rvalid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_rvalid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_rvalid
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: PC register, one-outstanding imem handshake FSM,
// single-entry hold buffer for responses arriving under stall, and the IF/ID register.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StallF,
    input  logic                  FlushD,
    input  logic                  PCSrc,
    input  logic [ADDR_WIDTH-1:0] PCTarget,
    fetch_imem_if.master          imem,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [ADDR_WIDTH-1:0] PCD,
    output logic [ADDR_WIDTH-1:0] PCPlus4D,
    output logic                  ValidD
);

    localparam logic [1:0] ST_REQ   = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~(ADDR_WIDTH'(3));
    localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(4);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pcf_q, pcf_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] pcd_q, pcd_d;
    logic [ADDR_WIDTH-1:0] pcp4_q, pcp4_d;
    logic                  valid_q, valid_d;

    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] target_al;
    logic                  req_raw;
    logic [ADDR_WIDTH-1:0] addr_raw;
    logic                  wait_take;
    logic                  hold_take;

    assign pc_plus4  = pcf_q + PC_STEP;
    assign target_al = PCTarget & WORD_MASK;

    // A fresh response consumed straight from memory, or the buffered one released.
    assign wait_take = (state_q == ST_WAIT) && imem.imem_rvalid && !StallF && !PCSrc;
    assign hold_take = (state_q == ST_HOLD) && !StallF && !PCSrc;

    always_comb begin
        state_d  = state_q;
        pcf_d    = pcf_q;
        hold_d   = hold_q;
        req_raw  = 1'b0;
        addr_raw = pcf_q;
        case (state_q)
            ST_REQ: begin
                req_raw = 1'b1;
                if (PCSrc) begin
                    pcf_d   = target_al;
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (PCSrc) begin
                    pcf_d   = target_al;
                    state_d = imem.imem_rvalid ? ST_REQ : ST_DRAIN;
                end else if (imem.imem_rvalid) begin
                    if (StallF) begin
                        hold_d  = imem.imem_rdata;
                        state_d = ST_HOLD;
                    end else begin
                        // Issue the next sequential fetch in the same cycle as the response.
                        req_raw  = 1'b1;
                        addr_raw = pc_plus4;
                        pcf_d    = pc_plus4;
                    end
                end
            end
            ST_DRAIN: begin
                if (PCSrc) begin
                    pcf_d = target_al;
                end
                if (imem.imem_rvalid) begin
                    state_d = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (PCSrc) begin
                    pcf_d   = target_al;
                    state_d = ST_REQ;
                end else if (!StallF) begin
                    pcf_d   = pc_plus4;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    assign imem.imem_req  = req_raw && !rst;
    assign imem.imem_addr = addr_raw & WORD_MASK;

    always_comb begin
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        if (FlushD || PCSrc) begin
            valid_d = 1'b0;
        end else if (!StallF) begin
            if (wait_take || hold_take) begin
                valid_d = 1'b1;
                instr_d = hold_take ? hold_q : imem.imem_rdata;
                pcd_d   = pcf_q;
                pcp4_d  = pc_plus4;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_REQ;
            pcf_q   <= RESET_PC & WORD_MASK;
            hold_q  <= '0;
            instr_q <= '0;
            pcd_q   <= '0;
            pcp4_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pcf_q   <= pcf_d;
            hold_q  <= hold_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
        end
    end

    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcp4_q;
    assign ValidD   = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural instruction memory with configurable response
// delay, expected-PC scoreboard consumed on each new IF/ID load, scenario tasks.
module tb_fetch_unit;
    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          StallF = 1'b0;
    logic          FlushD = 1'b0;
    logic          PCSrc = 1'b0;
    logic [AW-1:0] PCTarget = '0;
    logic [DW-1:0] InstrD, InstrD2;
    logic [AW-1:0] PCD, PCD2, PCPlus4D, PCPlus4D2;
    logic          ValidD, ValidD2;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [AW-1:0] exp_q[$];
    logic          sb_on = 1'b0;
    logic          last_stall = 1'b0;

    int            mem_lat = 1;
    logic          m_busy = 1'b0;
    int            m_cnt = 0;
    logic [AW-1:0] m_addr = '0;

    fetch_imem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    fetch_imem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

    fetch_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .StallF(StallF), .FlushD(FlushD), .PCSrc(PCSrc),
        .PCTarget(PCTarget), .imem(bus), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    fetch_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst), .StallF(1'b0), .FlushD(1'b0), .PCSrc(1'b0),
        .PCTarget({AW{1'b0}}), .imem(bus2), .InstrD(InstrD2), .PCD(PCD2),
        .PCPlus4D(PCPlus4D2), .ValidD(ValidD2)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] instr_of(input logic [AW-1:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    // Memory for dut: response mem_lat cycles after the request.
    always @(posedge clk) begin
        if (rst) begin
            m_busy           <= 1'b0;
            m_cnt            <= 0;
            bus.imem_rvalid  <= 1'b0;
        end else begin
            bus.imem_rvalid <= 1'b0;
            if (bus.imem_req) begin
                if (mem_lat <= 1) begin
                    bus.imem_rvalid <= 1'b1;
                    bus.imem_rdata  <= instr_of(bus.imem_addr);
                end else begin
                    m_busy <= 1'b1;
                    m_cnt  <= mem_lat - 1;
                    m_addr <= bus.imem_addr;
                end
            end else if (m_busy) begin
                if (m_cnt <= 1) begin
                    bus.imem_rvalid <= 1'b1;
                    bus.imem_rdata  <= instr_of(m_addr);
                    m_busy          <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    // Memory for dut2: always answers one cycle later.
    always @(posedge clk) begin
        if (rst) begin
            bus2.imem_rvalid <= 1'b0;
        end else begin
            bus2.imem_rvalid <= bus2.imem_req;
            bus2.imem_rdata  <= instr_of(bus2.imem_addr);
        end
    end

    always @(posedge clk) last_stall <= StallF;

    // Scoreboard consumer: a new IF/ID load is ValidD not held over by a stall.
    always @(negedge clk) begin
        logic [AW-1:0] e;
        if (!rst && bus.imem_req) begin
            n_cmp++;
            if (m_busy) begin
                n_bad++;
                $display("FAIL dup_req: request addr=%h while busy, required none", bus.imem_addr);
            end
        end
        if (sb_on && ValidD && !last_stall) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_extra: PCD=%h InstrD=%h, required no instruction", PCD, InstrD);
            end else begin
                e = exp_q.pop_front();
                if (PCD !== e || InstrD !== instr_of(e) || PCPlus4D !== e + 32'd4) begin
                    n_bad++;
                    $display("FAIL sb_instr: PCD=%h InstrD=%h PCPlus4D=%h, required %h %h %h",
                             PCD, InstrD, PCPlus4D, e, instr_of(e), e + 32'd4);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat);
        sb_on    = 1'b0;
        rst      = 1'b1;
        StallF   = 1'b0;
        FlushD   = 1'b0;
        PCSrc    = 1'b0;
        PCTarget = '0;
        mem_lat  = lat;
        exp_q.delete();
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic wait_drain(output int left);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        left  = exp_q.size();
        sb_on = 1'b0;
    endtask

    task automatic test_reset();
        mem_lat = 1;
        rst     = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        n_cmp++;
        if (bus.imem_req !== 1'b0 || ValidD !== 1'b0 || InstrD !== '0 || PCD !== '0 || PCPlus4D !== '0) begin
            n_bad++;
            $display("FAIL reset_init: req=%b v=%b instr=%h pcd=%h pc4=%h, required all 0",
                     bus.imem_req, ValidD, InstrD, PCD, PCPlus4D);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_first_req: req=%b addr=%h, required 1 00000000", bus.imem_req, bus.imem_addr);
        end
        repeat (5) tick();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_req_gate: req=%b, required 0", bus.imem_req);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (ValidD !== 1'b0 || InstrD !== '0 || PCD !== '0 || PCPlus4D !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: v=%b instr=%h pcd=%h pc4=%h, required all 0",
                     ValidD, InstrD, PCD, PCPlus4D);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_restart: req=%b addr=%h, required 1 00000000", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_stream();
        int left;
        do_reset(1);
        sb_on = 1'b1;
        for (int k = 0; k < 8; k++) exp_q.push_back(AW'(4 * k));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== AW'(4 * i)) begin
                n_bad++;
                $display("FAIL stream_addr c%0d: req=%b addr=%h, required 1 %h", i, bus.imem_req, bus.imem_addr, 4 * i);
            end
            if (i == 1 || i == 2) begin
                n_cmp++;
                if (ValidD !== (i == 2)) begin
                    n_bad++;
                    $display("FAIL stream_valid c%0d: ValidD=%b, required %b", i, ValidD, i == 2);
                end
            end
            tick();
        end
        wait_drain(left);
        n_cmp++;
        if (left != 0) begin
            n_bad++;
            $display("FAIL stream_drain: %0d left, required 0", left);
        end
    endtask

    task automatic test_latency();
        do_reset(4);
        sb_on = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back(AW'(4 * k));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.imem_req !== (i % 4 == 0) || (i % 4 == 0 && bus.imem_addr !== AW'(i))) begin
                n_bad++;
                $display("FAIL lat_req c%0d: req=%b addr=%h, required %b %h", i, bus.imem_req, bus.imem_addr, i % 4 == 0, i);
            end
            n_cmp++;
            if (ValidD !== (i >= 5 && i % 4 == 1)) begin
                n_bad++;
                $display("FAIL lat_valid c%0d: ValidD=%b, required %b", i, ValidD, i >= 5 && i % 4 == 1);
            end
            tick();
        end
        sb_on = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL lat_drain: %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_redirect();
        int left;
        do_reset(4);
        sb_on = 1'b1;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        for (int i = 0; i < 8; i++) begin
            PCSrc    = (i == 1);
            PCTarget = (i == 1) ? 32'h103 : 32'h0;
            @(negedge clk);
            if (i == 2) begin
                n_cmp++;
                if (ValidD !== 1'b0) begin
                    n_bad++;
                    $display("FAIL redir_valid: ValidD=%b, required 0", ValidD);
                end
            end
            if (i >= 2 && i <= 4) begin
                n_cmp++;
                if (bus.imem_req !== 1'b0) begin
                    n_bad++;
                    $display("FAIL redir_drain c%0d: req=%b, required 0", i, bus.imem_req);
                end
            end
            if (i == 5) begin
                n_cmp++;
                if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
                    n_bad++;
                    $display("FAIL redir_addr: req=%b addr=%h, required 1 00000100", bus.imem_req, bus.imem_addr);
                end
            end
            tick();
        end
        PCSrc = 1'b0;
        wait_drain(left);
        n_cmp++;
        if (left != 0) begin
            n_bad++;
            $display("FAIL redir_drain_sb: %0d left, required 0", left);
        end
    endtask

    task automatic test_stall_hold();
        int left;
        do_reset(1);
        sb_on = 1'b1;
        for (int k = 0; k < 6; k++) exp_q.push_back(AW'(4 * k));
        for (int i = 0; i < 10; i++) begin
            StallF = (i >= 3 && i <= 5);
            @(negedge clk);
            if (i >= 3 && i <= 6) begin
                n_cmp++;
                if (ValidD !== 1'b1 || PCD !== 32'h4 || InstrD !== instr_of(32'h4)) begin
                    n_bad++;
                    $display("FAIL stall_frozen c%0d: v=%b pcd=%h instr=%h, required 1 00000004 %h",
                             i, ValidD, PCD, InstrD, instr_of(32'h4));
                end
            end
            if (i >= 4 && i <= 6) begin
                n_cmp++;
                if (bus.imem_req !== 1'b0) begin
                    n_bad++;
                    $display("FAIL stall_hold_req c%0d: req=%b, required 0", i, bus.imem_req);
                end
            end
            if (i == 7) begin
                n_cmp++;
                if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) begin
                    n_bad++;
                    $display("FAIL stall_resume: req=%b addr=%h, required 1 0000000c", bus.imem_req, bus.imem_addr);
                end
            end
            tick();
        end
        StallF = 1'b0;
        wait_drain(left);
        n_cmp++;
        if (left != 0) begin
            n_bad++;
            $display("FAIL stall_drain: %0d left, required 0", left);
        end
    endtask

    task automatic test_hold_redirect();
        int left;
        do_reset(1);
        sb_on = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        PCTarget = 32'h200;
        for (int i = 0; i < 9; i++) begin
            StallF = (i >= 3 && i <= 5);
            PCSrc  = (i == 4);
            @(negedge clk);
            if (i == 4) begin
                n_cmp++;
                if (bus.imem_req !== 1'b0) begin
                    n_bad++;
                    $display("FAIL hredir_hold_req: req=%b, required 0", bus.imem_req);
                end
            end
            if (i == 5) begin
                n_cmp++;
                if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200 || ValidD !== 1'b0) begin
                    n_bad++;
                    $display("FAIL hredir_resume: req=%b addr=%h v=%b, required 1 00000200 0",
                             bus.imem_req, bus.imem_addr, ValidD);
                end
            end
            tick();
        end
        StallF = 1'b0;
        PCSrc  = 1'b0;
        wait_drain(left);
        n_cmp++;
        if (left != 0) begin
            n_bad++;
            $display("FAIL hredir_drain: %0d left, required 0", left);
        end
    endtask

    task automatic test_flush();
        int left;
        do_reset(1);
        sb_on = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'hC);
        exp_q.push_back(32'h10);
        exp_q.push_back(32'h14);
        for (int i = 0; i < 7; i++) begin
            FlushD = (i == 3);
            @(negedge clk);
            if (i == 4) begin
                n_cmp++;
                if (ValidD !== 1'b0 || PCD !== 32'h4) begin
                    n_bad++;
                    $display("FAIL flush_bubble: v=%b pcd=%h, required 0 00000004", ValidD, PCD);
                end
            end
            tick();
        end
        FlushD = 1'b0;
        wait_drain(left);
        n_cmp++;
        if (left != 0) begin
            n_bad++;
            $display("FAIL flush_drain: %0d left, required 0", left);
        end
    endtask

    task automatic test_wrap();
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0 || i == 1) begin
                n_cmp++;
                if (bus2.imem_req !== 1'b1 || bus2.imem_addr !== ((i == 0) ? 32'hFFFF_FFFC : 32'h0)) begin
                    n_bad++;
                    $display("FAIL wrap_addr c%0d: req=%b addr=%h", i, bus2.imem_req, bus2.imem_addr);
                end
            end
            if (i == 2) begin
                n_cmp++;
                if (ValidD2 !== 1'b1 || PCD2 !== 32'hFFFF_FFFC || PCPlus4D2 !== 32'h0 ||
                    InstrD2 !== instr_of(32'hFFFF_FFFC)) begin
                    n_bad++;
                    $display("FAIL wrap_d0: v=%b pcd=%h pc4=%h instr=%h, required 1 fffffffc 00000000 %h",
                             ValidD2, PCD2, PCPlus4D2, InstrD2, instr_of(32'hFFFF_FFFC));
                end
            end
            if (i == 3) begin
                n_cmp++;
                if (ValidD2 !== 1'b1 || PCD2 !== 32'h0 || PCPlus4D2 !== 32'h4) begin
                    n_bad++;
                    $display("FAIL wrap_d1: v=%b pcd=%h pc4=%h, required 1 00000000 00000004",
                             ValidD2, PCD2, PCPlus4D2);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_latency();
        test_redirect();
        test_stall_hold();
        test_hold_redirect();
        test_flush();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
